// File: rtl/nor_flash_model.sv
// Cycle-based model of the x16 parallel NOR flash: array read, unlocked word program, sector erase, busy/status polling.
// Optional build macro NOR_MODEL_STRICT_EN: a program that would set a bit 0->1 is rejected and latches DQ5.
module nor_flash_model #(
    parameter int MEM_AW    = 12,
    parameter int SECT_AW   = 8,
    parameter int READ_LAT  = 3,
    parameter int PROG_CYC  = 16,
    parameter int ERASE_CYC = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [25:0] nor_addr_i,
    input  logic [15:0] nor_data_i,
    input  logic        nor_ce_i,
    input  logic        nor_we_i,
    input  logic        nor_oe_i,
    output logic [15:0] nor_data_o,
    output logic        nor_data_oe,
    output logic        nor_ry_o
);

    localparam int DEPTH   = 1 << MEM_AW;
    localparam int CNT_MAX = (ERASE_CYC > PROG_CYC) ? ERASE_CYC : PROG_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LAT_W   = $clog2(READ_LAT + 1);
    localparam int SECT_W  = MEM_AW - SECT_AW;

    typedef enum logic [3:0] {
        READ, UNLK1, UNLK2, PROG_ARM, ERS_UNLK0, ERS_UNLK1, ERS_UNLK2, PROG_BUSY, ERASE_BUSY
    } state_t;

    logic [15:0] mem [DEPTH] = '{default: 16'hFFFF};

    logic [25:0]        addr_p0;
    logic [15:0]        data_p0;
    logic               ce_p0, we_p0, oe_p0;
    state_t             state, state_d;
    logic [CNT_W-1:0]   busy_cnt, busy_cnt_d;
    logic [LAT_W-1:0]   rd_cnt;
    logic               toggle, dq7_st, dq7_d, dq5_st, dq5_d;
    logic [SECT_W-1:0]  ers_sect, ers_sect_d;
    logic               prog_we, erase_fill;
    logic               wr_evt, busy, rd_active, prog_ok, is_f0;
    logic [10:0]        cmd_addr;
    logic [7:0]         cmd_byte;
    logic [MEM_AW-1:0]  wr_idx;
    logic [15:0]        cur_word, rd_word, status_word;
    logic               unused_bits;

    assign unused_bits = ^{nor_addr_i[25:MEM_AW], addr_p0[25:MEM_AW]};

    // Input sample stage: the write strobe edge uses the previous cycle's address and data.
    always_ff @(posedge clk_i) begin
        addr_p0 <= nor_addr_i;
        data_p0 <= nor_data_i;
    end

    assign wr_evt    = ~we_p0 & nor_we_i & ~ce_p0;
    assign cmd_addr  = addr_p0[10:0];
    assign cmd_byte  = data_p0[7:0];
    assign is_f0     = (cmd_byte == 8'hF0);
    assign wr_idx    = addr_p0[MEM_AW-1:0];
    assign cur_word  = mem[wr_idx];
    assign busy      = (state == PROG_BUSY) || (state == ERASE_BUSY);
    assign nor_ry_o  = ~busy;
    assign rd_active = ~nor_ce_i & ~nor_oe_i & nor_we_i;
    assign status_word = {8'h00, dq7_st, toggle, dq5_st, 5'b00000};
    assign rd_word   = busy ? status_word : mem[nor_addr_i[MEM_AW-1:0]];

`ifdef NOR_MODEL_STRICT_EN
    assign prog_ok = ((data_p0 & ~cur_word) == 16'h0000);
`else
    assign prog_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state;
        busy_cnt_d = busy_cnt;
        dq7_d      = dq7_st;
        dq5_d      = dq5_st;
        ers_sect_d = ers_sect;
        prog_we    = 1'b0;
        erase_fill = 1'b0;
        if (busy) begin
            if (dq5_st) begin
                // A rejected program stays busy until software issues the reset command.
                if (wr_evt && is_f0) begin
                    state_d = READ;
                    dq5_d   = 1'b0;
                end
            end else if (busy_cnt <= CNT_W'(1)) begin
                state_d    = READ;
                busy_cnt_d = '0;
                erase_fill = (state == ERASE_BUSY);
            end else begin
                busy_cnt_d = busy_cnt - CNT_W'(1);
            end
        end else if (wr_evt) begin
            if (is_f0) begin
                state_d = READ;
            end else begin
                state_d = READ;
                case (state)
                    READ:
                        if (cmd_addr == 11'h555 && cmd_byte == 8'hAA) state_d = UNLK1;
                    UNLK1:
                        if (cmd_addr == 11'h2AA && cmd_byte == 8'h55) state_d = UNLK2;
                    UNLK2: begin
                        if (cmd_addr == 11'h555 && cmd_byte == 8'hA0) state_d = PROG_ARM;
                        if (cmd_addr == 11'h555 && cmd_byte == 8'h80) state_d = ERS_UNLK0;
                    end
                    PROG_ARM: begin
                        state_d    = PROG_BUSY;
                        busy_cnt_d = CNT_W'(PROG_CYC);
                        dq7_d      = ~data_p0[7];
                        dq5_d      = ~prog_ok;
                        prog_we    = prog_ok;
                    end
                    ERS_UNLK0:
                        if (cmd_addr == 11'h555 && cmd_byte == 8'hAA) state_d = ERS_UNLK1;
                    ERS_UNLK1:
                        if (cmd_addr == 11'h2AA && cmd_byte == 8'h55) state_d = ERS_UNLK2;
                    ERS_UNLK2:
                        if (cmd_byte == 8'h30) begin
                            state_d    = ERASE_BUSY;
                            busy_cnt_d = CNT_W'(ERASE_CYC);
                            dq7_d      = 1'b0;
                            dq5_d      = 1'b0;
                            ers_sect_d = addr_p0[MEM_AW-1:SECT_AW];
                        end
                    default: state_d = READ;
                endcase
            end
        end
    end

    // Control stage: FSM, strobe history, read latency counter and output bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= READ;
            busy_cnt    <= '0;
            rd_cnt      <= '0;
            toggle      <= 1'b0;
            dq7_st      <= 1'b0;
            dq5_st      <= 1'b0;
            ce_p0       <= 1'b1;
            we_p0       <= 1'b1;
            oe_p0       <= 1'b1;
            nor_data_o  <= 16'h0000;
            nor_data_oe <= 1'b0;
        end else begin
            state    <= state_d;
            busy_cnt <= busy_cnt_d;
            dq7_st   <= dq7_d;
            dq5_st   <= dq5_d;
            ce_p0    <= nor_ce_i;
            we_p0    <= nor_we_i;
            oe_p0    <= nor_oe_i;
            if (!rd_active)
                rd_cnt <= '0;
            else if (rd_cnt != LAT_W'(READ_LAT))
                rd_cnt <= rd_cnt + LAT_W'(1);
            nor_data_oe <= rd_active && (rd_cnt >= LAT_W'(READ_LAT - 1));
            if (rd_active && rd_cnt == LAT_W'(READ_LAT - 1))
                nor_data_o <= rd_word;
            if (busy && ~oe_p0 && nor_oe_i && ~ce_p0)
                toggle <= ~toggle;
        end
    end

    always_ff @(posedge clk_i) begin
        ers_sect <= ers_sect_d;
    end

    // Array update stage: a program commits with the write; an erase only at countdown end.
    always_ff @(posedge clk_i) begin
        if (!rst_i && prog_we)
            mem[wr_idx] <= cur_word & data_p0;
        if (!rst_i && erase_fill)
            for (int i = 0; i < (1 << SECT_AW); i++)
                mem[{ers_sect, SECT_AW'(i)}] <= 16'hFFFF;
    end

endmodule

// File: tb/tb_nor_flash_model.sv
// Directed bench for nor_flash_model: read latency, program, AND-merge, erase, aborts, reset, aliasing.
// Read expectations go through a scoreboard queue; build with NOR_MODEL_STRICT_EN to exercise strict mode.
module tb_nor_flash_model;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] nor_addr;
    logic [15:0] nor_din;
    logic        nor_ce, nor_we, nor_oe;
    logic [15:0] nor_dout;
    logic        nor_data_oe;
    logic        nor_ry;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ry_low = 0;
    logic        tog = 1'b0;
    logic [15:0] exp_q[$];
    int          s0;

`ifdef NOR_MODEL_STRICT_EN
    localparam logic [15:0] W40 = 16'h0000;
`else
    localparam logic [15:0] W40 = 16'h0034;
`endif

    nor_flash_model dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .nor_addr_i (nor_addr),
        .nor_data_i (nor_din),
        .nor_ce_i   (nor_ce),
        .nor_we_i   (nor_we),
        .nor_oe_i   (nor_oe),
        .nor_data_o (nor_dout),
        .nor_data_oe(nor_data_oe),
        .nor_ry_o   (nor_ry)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (nor_ry === 1'b0) ry_low <= ry_low + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [25:0] a, input logic [15:0] d);
        @(negedge clk);
        nor_addr = a; nor_din = d; nor_ce = 1'b0; nor_we = 1'b0;
        @(negedge clk);
        nor_we = 1'b1;
        @(negedge clk);
        nor_ce = 1'b1;
    endtask

    task automatic rd(input logic [25:0] a, input logic [15:0] exp, input string tag);
        int lat;
        logic [15:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        nor_addr = a; nor_ce = 1'b0; nor_oe = 1'b0;
        lat = 0;
        while (nor_data_oe !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, 3);
        want = exp_q.pop_front();
        check(tag, nor_dout, want);
        nor_ce = 1'b1; nor_oe = 1'b1;
        @(negedge clk);
        check("rd_oe_drop", nor_data_oe, 1'b0);
    endtask

    task automatic wait_ready(input int max, input string tag);
        int n = 0;
        while (nor_ry !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, nor_ry, 1'b1);
    endtask

    task automatic unlock_prog();
        wr(26'h555, 16'h00AA);
        wr(26'h2AA, 16'h0055);
        wr(26'h555, 16'h00A0);
    endtask

    task automatic unlock_erase();
        wr(26'h555, 16'h00AA);
        wr(26'h2AA, 16'h0055);
        wr(26'h555, 16'h0080);
        wr(26'h555, 16'h00AA);
        wr(26'h2AA, 16'h0055);
    endtask

    initial begin
        rst = 1'b1; nor_addr = '0; nor_din = '0;
        nor_ce = 1'b1; nor_we = 1'b1; nor_oe = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", nor_dout, 16'h0000);
        check("rst_oe", nor_data_oe, 1'b0);
        check("rst_ry", nor_ry, 1'b1);
        rst = 1'b0;

        rd(26'h10, 16'hFFFF, "rd_after_reset");
        check("ry_idle", nor_ry, 1'b1);

        unlock_prog();
        s0 = ry_low;
        wr(26'h40, 16'h1234);
        check("prog_ry_low", nor_ry, 1'b0);
        rd(26'h40, {8'h00, 1'b1, tog, 1'b0, 5'b0}, "prog_status1");
        tog = ~tog;
        rd(26'h40, {8'h00, 1'b1, tog, 1'b0, 5'b0}, "prog_status2");
        tog = ~tog;
        wait_ready(100, "prog_done");
        check("prog_busy_len", ry_low - s0, 16);
        rd(26'h40, 16'h1234, "prog_readback");

`ifdef NOR_MODEL_STRICT_EN
        unlock_prog();
        wr(26'h40, 16'h0000);
        wait_ready(100, "strict_clear_done");
        rd(26'h40, 16'h0000, "strict_clear_rb");
        unlock_prog();
        wr(26'h40, 16'hFFFF);
        repeat (300) @(negedge clk);
        check("strict_stuck_busy", nor_ry, 1'b0);
        rd(26'h40, {8'h00, 1'b0, tog, 1'b1, 5'b0}, "strict_status");
        tog = ~tog;
        wr(26'h123, 16'h00F0);
        check("strict_f0_exit", nor_ry, 1'b1);
        rd(26'h40, 16'h0000, "strict_rb");
`else
        unlock_prog();
        wr(26'h40, 16'h00FF);
        wait_ready(100, "and_done");
        rd(26'h40, 16'h0034, "and_readback");
`endif

        unlock_prog();
        wr(26'h140, 16'h0000);
        wait_ready(100, "prog140_done");
        unlock_prog();
        wr(26'h0FF, 16'h5A5A);
        wait_ready(100, "prog0ff_done");
        rd(26'h140, 16'h0000, "pre_erase_140");
        unlock_erase();
        s0 = ry_low;
        wr(26'h100, 16'h0030);
        rd(26'h140, {8'h00, 1'b0, tog, 1'b0, 5'b0}, "erase_status");
        tog = ~tog;
        wait_ready(2000, "erase_done");
        check("erase_busy_min", (ry_low - s0) >= 256, 1'b1);
        rd(26'h140, 16'hFFFF, "erase_140");
        rd(26'h040, W40, "erase_other_sector");
        rd(26'h0FF, 16'h5A5A, "erase_boundary");

        wr(26'h555, 16'h00AA);
        wr(26'h2AA, 16'h0099);
        wr(26'h2AA, 16'h0055);
        wr(26'h555, 16'h00A0);
        wr(26'h10, 16'h0000);
        check("abort_no_prog", nor_ry, 1'b1);
        rd(26'h10, 16'hFFFF, "abort_read");

        unlock_prog();
        wr(26'h150, 16'h1111);
        wait_ready(100, "prog150_done");
        unlock_erase();
        wr(26'h1A0, 16'h0030);
        repeat (20) @(negedge clk);
        check("erase_mid_busy", nor_ry, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tog = 1'b0;
        check("rst_mid_ry", nor_ry, 1'b1);
        check("rst_mid_data", nor_dout, 16'h0000);
        repeat (300) @(negedge clk);
        check("rst_mid_stays_ready", nor_ry, 1'b1);
        rd(26'h150, 16'h1111, "rst_mid_unchanged");

        wr(26'h3FFF555, 16'h00AA);
        wr(26'h3FFF2AA, 16'h0055);
        wr(26'h0800555, 16'h00A0);
        wr(26'h1000010, 16'hC3C3);
        wait_ready(100, "alias_prog_done");
        rd(26'h10, 16'hC3C3, "alias_low");
        rd(26'h1000010, 16'hC3C3, "alias_high");

        @(negedge clk);
        nor_addr = 26'h0; nor_din = 16'h0000;
        nor_ce = 1'b0; nor_oe = 1'b0; nor_we = 1'b0;
        repeat (5) @(negedge clk);
        check("wr_rd_overlap_oe", nor_data_oe, 1'b0);
        nor_we = 1'b1; nor_ce = 1'b1; nor_oe = 1'b1;
        repeat (2) @(negedge clk);
        check("overlap_ry", nor_ry, 1'b1);
        rd(26'h10, 16'hC3C3, "overlap_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
